// File: rtl/sub4_serial_pkg.sv
// sub4_serial_pkg: FSM state encoding and default operand width for sub4_serial
package sub4_serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/sub4_serial_sub_bit_cell.sv
// sub_bit_cell: combinational 1-bit full subtractor (a - b - br -> d, br_next)
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic br_next
);
  assign d       = a ^ b ^ br;
  assign br_next = (~a & b) | (~(a ^ b) & br);
endmodule

// File: rtl/sub4_serial.sv
// sub4_serial: LSB-first bit-serial {bo,diff}=a-b-bi with valid/ready on both sides; ovf port only with SUB4_SERIAL_OVF_EN
module sub4_serial
  import sub4_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo
`ifdef SUB4_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, res;
  logic br, d, br_n, last;
  assign last = cnt == CW'(WIDTH - 1);
  sub_bit_cell u_cell (
    .a      (ra[cnt]),
    .b      (rb[cnt]),
    .br     (br),
    .d      (d),
    .br_next(br_n)
  );
  always_comb
    nxt = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
          state == SHIFT ? (last ? DONE : SHIFT) :
                           (out_ready ? IDLE : DONE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      res   <= '0;
      br    <= 1'b0;
`ifdef SUB4_SERIAL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        ra  <= a;
        rb  <= b;
        br  <= bi;
        cnt <= '0;
        res <= '0;
      end else if (state == SHIFT) begin
        res <= {d, res[WIDTH-1:1]};
        br  <= br_n;
        cnt <= last ? '0 : cnt + 1'b1;
`ifdef SUB4_SERIAL_OVF_EN
        if (last) ovf <= (ra[WIDTH-1] ^ rb[WIDTH-1]) & (d ^ ra[WIDTH-1]);
`endif
      end
    end
  end
  assign in_ready  = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign diff      = res;
  assign bo        = br;
endmodule

// File: tb/tb_sub4_serial.sv
// tb_sub4_serial: directed self-checking bench for sub4_serial
module tb_sub4_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic bi = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [3:0] diff;
  logic bo;
`ifdef SUB4_SERIAL_OVF_EN
  logic ovf;
`endif
  int checks = 0;
  int errors = 0;

  sub4_serial #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bi       (bi),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bo       (bo)
`ifdef SUB4_SERIAL_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic start(input logic [3:0] ta, input logic [3:0] tb, input logic tbi);
    a = ta;
    b = tb;
    bi = tbi;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb;
    bi = ~tbi;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (diff !== 4'h0) begin errors++; $display("FAIL reset_diff got %h want 0", diff); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL reset_bo got %b want 0", bo); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during got %b want 0", in_ready); end
`ifdef SUB4_SERIAL_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_after got %b want 0", out_valid); end
  endtask

  task automatic test_basic;
    int lat;
    out_ready = 1'b1;
    start(4'd5, 4'd3, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", in_ready); end
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++; if (diff !== 4'd2) begin errors++; $display("FAIL basic_diff got %h want 2", diff); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_bo got %b want 0", bo); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_borrow;
    logic [3:0] va [4] = '{4'd3, 4'd0, 4'd15, 4'd10};
    logic [3:0] vb [4] = '{4'd5, 4'd0, 4'd15, 4'd3};
    logic       vi [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] ed [4] = '{4'hE, 4'hF, 4'hF, 4'h6};
    logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start(va[i], vb[i], vi[i]);
      wait_valid(lat);
      checks++; if (out_valid !== 1'b1 || diff !== ed[i] || bo !== eb[i])
        begin errors++; $display("FAIL borrow_%0d got valid=%b diff=%h bo=%b want 1 %h %b", i, out_valid, diff, bo, ed[i], eb[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall;
    int lat;
    out_ready = 1'b0;
    start(4'd6, 4'd1, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL stall_latency got %0d want 4", lat); end
    a = 4'd9;
    b = 4'd4;
    bi = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if ({out_valid, diff, bo, in_ready} !== {1'b1, 4'd5, 1'b0, 1'b0})
        begin errors++; $display("FAIL stall_hold_%0d got valid=%b diff=%h bo=%b ready=%b want 1 5 0 0", i, out_valid, diff, bo, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_accept got ready=%b want 0", in_ready); end
    in_valid = 1'b0;
    a = 4'd0;
    b = 4'd15;
    wait_valid(lat);
    checks++; if (lat !== 4 || diff !== 4'd5 || bo !== 1'b0)
      begin errors++; $display("FAIL stall_next got lat=%0d diff=%h bo=%b want 4 5 0", lat, diff, bo); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    out_ready = 1'b1;
    start(4'd12, 4'd5, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({out_valid, diff, bo, in_ready} !== 7'b0)
      begin errors++; $display("FAIL midrst_clear got valid=%b diff=%h bo=%b ready=%b want 0 0 0 0", out_valid, diff, bo, in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    checks++; if (lat !== 0) begin errors++; $display("FAIL midrst_stale got %0d valid cycles want 0", lat); end
    start(4'd7, 4'd2, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 4 || diff !== 4'd5 || bo !== 1'b0)
      begin errors++; $display("FAIL midrst_next got lat=%0d diff=%h bo=%b want 4 5 0", lat, diff, bo); end
    @(posedge clk); #1;
  endtask

`ifdef SUB4_SERIAL_OVF_EN
  task automatic test_ovf;
    int lat;
    out_ready = 1'b1;
    start(4'd8, 4'd1, 1'b0);
    wait_valid(lat);
    checks++; if (diff !== 4'd7 || bo !== 1'b0 || ovf !== 1'b1)
      begin errors++; $display("FAIL ovf_set got diff=%h bo=%b ovf=%b want 7 0 1", diff, bo, ovf); end
    @(posedge clk); #1;
    start(4'd2, 4'd1, 1'b0);
    wait_valid(lat);
    checks++; if (diff !== 4'd1 || bo !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL ovf_clear got diff=%h bo=%b ovf=%b want 1 0 0", diff, bo, ovf); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_stall;
    test_reset_mid;
`ifdef SUB4_SERIAL_OVF_EN
    test_ovf;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
